imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU status for imem_loader.
interface imem_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic [8:0]  word_count;

  // Source side: drives the stream and start, observes the loader.
  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, word_count
  );

  // Loader side.
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the CPU until the whole program has been written.
module imem_loader (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_len, w_len_nxt;
  logic [WORD_W-1:0]   r_word, w_word_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_we, w_we_nxt;
  logic                r_rdy, w_rdy_nxt;
  logic                r_hold, w_hold_nxt;
  logic                r_done, w_done_nxt;
  logic                w_hs;

  // A byte transfers when the source is valid and the loader advertised ready.
  assign w_hs = bus.in_valid && r_rdy;

  // State and datapath registers; outputs are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_len   <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_rdy   <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_word  <= w_word_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_rdy   <= w_rdy_nxt;
      r_hold  <= w_hold_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_word_nxt  = r_word;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_rdy_nxt   = 1'b0;
    w_hold_nxt  = 1'b1;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_hs) begin
          // A length byte of zero means a full 256-word program.
          w_len_nxt   = (bus.in_data == 8'd0) ? CNT_W'(256) : CNT_W'(bus.in_data);
          w_idx_nxt   = 2'd0;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          unique case (r_idx)
            2'd0: w_word_nxt[7:0]   = bus.in_data;
            2'd1: w_word_nxt[15:8]  = bus.in_data;
            2'd2: w_word_nxt[23:16] = bus.in_data;
            2'd3: w_word_nxt[31:24] = bus.in_data;
            default: w_word_nxt = r_word;
          endcase
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_addr_nxt  = r_addr + ADDR_W'(1);
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_state_nxt = (w_cnt_nxt == r_len) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        if (bus.start) w_state_nxt = S_LEN;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_we_nxt   = (w_state_nxt == S_WRITE);
    w_rdy_nxt  = (w_state_nxt == S_LEN) || (w_state_nxt == S_DATA);
    w_hold_nxt = (w_state_nxt != S_DONE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign bus.in_ready   = r_rdy;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_word;
  assign bus.cpu_hold   = r_hold;
  assign bus.done       = r_done;
  assign bus.word_count = r_cnt;

  logic unused_ok;
  assign unused_ok = &{1'b0, DATA_W[0]};
endmodule
